// File: rtl/mux_scan_pkg.sv
// Shared mode encodings for the scanning display multiplexer.
package mux_scan_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        M_DIRECT = MODE_DIRECT,
        M_STEP   = MODE_STEP,
        M_SCAN   = MODE_SCAN,
        M_HOLD   = MODE_HOLD
    } mode_t;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser for asynchronous board inputs, with an optional
// rising-edge strobe taken from a third flop behind the synchronised value.
module input_sync #(
    parameter int W    = 1,
    parameter bit EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

    if (EDGE) begin : g_edge
        logic [W-1:0] q_d;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_d <= '0;
            else        q_d <= q;
        end
        assign rise = q & ~q_d;
    end else begin : g_no_edge
        assign rise = '0;
    end

endmodule

// File: rtl/mux_scan_nxw.sv
// N-channel, W-bit registered display multiplexer with direct, step,
// timed-scan and hold channel selection.
//
//   mode   | meaning
//   DIRECT | channel follows synchronised SEL; out-of-range SEL ignored
//   STEP   | channel advances (with wrap) once per STEP press
//   SCAN   | channel advances (with wrap) every DWELL cycles
//   HOLD   | channel and DATA_OUT frozen; presses discarded
module mux_scan_nxw
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 50000000,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
    input  logic [SEL_W-1:0]          SEL,
    input  logic [1:0]                MODE,
    input  logic                      STEP,
    output logic [WIDTH-1:0]          DATA_OUT,
    output logic [SEL_W-1:0]          CH_OUT,
    output logic                      CH_CHANGE
);

    if (CHANNELS < 2 || WIDTH < 1 || DWELL < 1) begin : g_param_check
        $error("mux_scan_nxw: need CHANNELS>=2, WIDTH>=1, DWELL>=1");
    end

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   NUM_CH    = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] sel_s;
    logic [1:0]       mode_s;
    logic             step_s;
    logic             step_rise;
    logic [SEL_W-1:0] sel_unused_rise;
    logic [1:0]       mode_unused_rise;

    input_sync #(.W(SEL_W), .EDGE(1'b0)) u_sel_sync (
        .clk(CLOCK_50), .rst_n(RESET_N), .d(SEL), .q(sel_s), .rise(sel_unused_rise)
    );

    input_sync #(.W(2), .EDGE(1'b0)) u_mode_sync (
        .clk(CLOCK_50), .rst_n(RESET_N), .d(MODE), .q(mode_s), .rise(mode_unused_rise)
    );

    input_sync #(.W(1), .EDGE(1'b1)) u_step_sync (
        .clk(CLOCK_50), .rst_n(RESET_N), .d(STEP), .q(step_s), .rise(step_rise)
    );

    logic [SEL_W-1:0] ch;
    logic [SEL_W-1:0] ch_next;
    logic [SEL_W-1:0] ch_adv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] data_next;

    // Wrap by compare so non-power-of-two channel counts never reach unused codes.
    assign ch_adv = (ch == LAST_CH) ? '0 : ch + 1'b1;

    always_comb begin
        ch_next  = ch;
        cnt_next = '0;
        case (mode_t'(mode_s))
            M_DIRECT: begin
                if ({1'b0, sel_s} < NUM_CH) ch_next = sel_s;
            end
            M_STEP: begin
                if (step_rise) ch_next = ch_adv;
            end
            M_SCAN: begin
                if (cnt == CNT_LAST) begin
                    ch_next = ch_adv;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        data_next = DATA_IN[int'(ch_next)*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ch        <= '0;
            cnt       <= '0;
            DATA_OUT  <= '0;
            CH_CHANGE <= 1'b0;
        end else begin
            ch        <= ch_next;
            cnt       <= cnt_next;
            CH_CHANGE <= (ch_next != ch);
            if (mode_s != MODE_HOLD) DATA_OUT <= data_next;
        end
    end

    assign CH_OUT = ch;

endmodule

// File: tb/tb_mux_scan_nxw.sv
// Directed bench for mux_scan_nxw: a 4-channel and a 3-channel instance
// sharing clock and reset, DWELL=3.
module tb_mux_scan_nxw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data0 = 16'hA5C3;
    logic [1:0]  sel0 = 2'd0;
    logic [1:0]  mode0 = 2'b00;
    logic        step0 = 1'b0;
    logic [3:0]  dout0;
    logic [1:0]  ch0;
    logic        chg0;

    logic [11:0] data1 = 12'h5C3;
    logic [1:0]  sel1 = 2'd0;
    logic [1:0]  mode1 = 2'b00;
    logic        step1 = 1'b0;
    logic [3:0]  dout1;
    logic [1:0]  ch1;
    logic        chg1;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses;
    int exp_ch;

    logic [3:0] nib4 [4];
    logic [3:0] nib3 [3];

    always #5 clk = ~clk;

    mux_scan_nxw #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut0 (
        .CLOCK_50(clk), .RESET_N(rst_n), .DATA_IN(data0), .SEL(sel0),
        .MODE(mode0), .STEP(step0), .DATA_OUT(dout0), .CH_OUT(ch0), .CH_CHANGE(chg0)
    );

    mux_scan_nxw #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .DATA_IN(data1), .SEL(sel1),
        .MODE(mode1), .STEP(step1), .DATA_OUT(dout1), .CH_OUT(ch1), .CH_CHANGE(chg1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        nib4[0] = 4'h3; nib4[1] = 4'hC; nib4[2] = 4'h5; nib4[3] = 4'hA;
        nib3[0] = 4'h3; nib3[1] = 4'hC; nib3[2] = 4'h5;

        // 1: reset asserted mid-scan, between clock edges
        #12 rst_n = 1'b1;
        tick(1);
        mode0 = 2'b10;
        tick(8);
        chk("scan_before_reset_ch", ch0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", dout0, 0);
        chk("rst_ch", ch0, 0);
        chk("rst_chg", chg0, 0);
        mode0 = 2'b00;
        sel0  = 2'd0;
        #2 rst_n = 1'b1;
        tick(3);
        chk("post_rst_dout", dout0, 4'h3);
        chk("post_rst_ch", ch0, 0);

        // 2: direct select, 3-edge latency, live data follow
        sel0 = 2'd2;
        tick(2);
        chk("direct_ch_edge2", ch0, 0);
        tick(1);
        chk("direct_ch", ch0, 2);
        chk("direct_dout", dout0, 4'h5);
        chk("direct_chg", chg0, 1);
        tick(1);
        chk("direct_chg_clear", chg0, 0);
        data0 = 16'hA7C3;
        tick(1);
        chk("direct_data_follow", dout0, 4'h7);
        chk("direct_data_no_chg", chg0, 0);

        // 3: step mode, held button advances once
        sel0 = 2'd3;
        tick(4);
        chk("step_start_ch", ch0, 3);
        mode0 = 2'b01;
        tick(3);
        step0 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (chg0) pulses++;
        end
        chk("step_hold_pulses", pulses, 1);
        chk("step_wrap_ch", ch0, 0);
        chk("step_wrap_dout", dout0, 4'h3);
        step0 = 1'b0;
        tick(3);
        step0 = 1'b1;
        tick(2);
        chk("step_edge2_ch", ch0, 0);
        tick(1);
        chk("step2_ch", ch0, 1);
        chk("step2_dout", dout0, 4'hC);
        step0 = 1'b0;

        // 4: timed scan from ch0
        data0 = 16'hA5C3;
        mode0 = 2'b00;
        sel0  = 2'd0;
        tick(4);
        chk("scan_start_ch", ch0, 0);
        mode0 = 2'b10;
        for (int t = 1; t <= 16; t++) begin
            tick(1);
            exp_ch = (t < 5) ? 0 : (((t - 5) / 3 + 1) % 4);
            chk($sformatf("scan_ch_t%0d", t), ch0, exp_ch);
            chk($sformatf("scan_dout_t%0d", t), dout0, nib4[exp_ch]);
            chk($sformatf("scan_chg_t%0d", t), chg0, (t >= 5 && (t - 5) % 3 == 0) ? 1 : 0);
        end

        // 5: hold freezes channel and data, discards presses
        mode0 = 2'b00;
        sel0  = 2'd2;
        tick(5);
        chk("hold_start_ch", ch0, 2);
        mode0 = 2'b11;
        tick(2);
        data0 = 16'hFFFF;
        step0 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 2) step0 = 1'b0;
            if (chg0) pulses++;
        end
        chk("hold_dout", dout0, 4'h5);
        chk("hold_ch", ch0, 2);
        chk("hold_no_chg", pulses, 0);
        mode0 = 2'b00;
        tick(2);
        chk("hold_exit_edge2_dout", dout0, 4'h5);
        tick(1);
        chk("hold_exit_dout", dout0, 4'hF);

        // 6: three channels, out-of-range select and scan wrap
        sel1 = 2'd1;
        tick(3);
        chk("n3_direct_ch", ch1, 1);
        chk("n3_direct_dout", dout1, 4'hC);
        sel1 = 2'd3;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (chg1) pulses++;
        end
        chk("n3_oor_ch", ch1, 1);
        chk("n3_oor_no_chg", pulses, 0);
        sel1 = 2'd2;
        tick(4);
        chk("n3_scan_start_ch", ch1, 2);
        mode1 = 2'b10;
        for (int t = 1; t <= 13; t++) begin
            tick(1);
            exp_ch = (2 + ((t >= 5) ? ((t - 5) / 3 + 1) : 0)) % 3;
            chk($sformatf("n3_scan_ch_t%0d", t), ch1, exp_ch);
            chk($sformatf("n3_scan_dout_t%0d", t), dout1, nib3[exp_ch]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_nxw.md
Name: mux_scan_nxw

Overview:
Parametrised N-channel, W-bit registered multiplexer, the successor to the board's fixed 4-bit 2-to-1 switch mux. It selects one of CHANNELS packed input words for display on LEDs. The channel is chosen in one of four modes: direct select, button step, timed auto-scan, or hold. It sits between the board switch/button inputs and the LED/7-seg display drivers.

Parameters:
WIDTH, 4, bits per channel (>=1)
CHANNELS, 4, number of input channels (>=2; need not be a power of two)
DWELL, 50000000, clock cycles per channel in SCAN mode (>=1; default is 1 s at 50 MHz)
SEL_W, $clog2(CHANNELS), localparam, channel index width

Ports:
CLOCK_50  input  1  system clock, only clock domain
RESET_N  input  1  reset, asynchronous assert, active-low
DATA_IN  input  CHANNELS*WIDTH  packed channels; channel i = DATA_IN[i*WIDTH +: WIDTH]; quasi-static, not synchronised
SEL  input  SEL_W  direct channel select from switches; asynchronous
MODE  input  2  00 DIRECT, 01 STEP, 10 SCAN, 11 HOLD; asynchronous
STEP  input  1  raw active-high step button level; asynchronous
DATA_OUT  output  WIDTH  registered selected channel data
CH_OUT  output  SEL_W  registered current channel index
CH_CHANGE  output  1  one-cycle pulse when CH_OUT changes

Behaviour:
- Reset (RESET_N low, asynchronous): DATA_OUT=0, CH_OUT=0, CH_CHANGE=0, dwell counter=0, all synchroniser and edge flops=0. Outputs hold these values until the first clock edge after release.
- Synchronisers: SEL, MODE and STEP each pass through a 2-flop synchroniser (sel_s, mode_s, step_s).
- STEP edge: step_rise = step_s & ~step_d. A held button gives exactly one rise.
- Channel register ch drives CH_OUT. ch_next is chosen per mode_s:
  - DIRECT: ch_next = sel_s if sel_s < CHANNELS; otherwise ch is unchanged (out-of-range values are ignored).
  - STEP: on step_rise, ch_next = (ch == CHANNELS-1) ? 0 : ch+1; otherwise unchanged.
  - SCAN: the counter runs 0..DWELL-1. At DWELL-1 the counter returns to 0 and ch advances with wrap, as in STEP.
  - HOLD: ch is unchanged. step_rise is discarded, not queued.
- Dwell counter:
  - Forced to 0 in every cycle mode_s is not SCAN.
  - On entry to SCAN, the first advance occurs DWELL cycles after mode_s becomes SCAN.
  - DWELL=1 advances every cycle.
- DATA_OUT:
  - In non-HOLD modes, DATA_OUT <= DATA_IN slice of ch_next every cycle, so DATA_OUT and CH_OUT are always consistent in the same cycle.
  - DATA_IN to DATA_OUT latency is 1 cycle.
  - In HOLD, DATA_OUT is frozen even if DATA_IN changes.
- CH_CHANGE: registered (ch_next != ch). It is high for exactly the first cycle CH_OUT shows a new value, and never high in HOLD.
- Latency:
  - SEL change to CH_OUT/DATA_OUT update: 3 rising edges (2 sync + 1 register).
  - STEP press to advance: 3 edges (2 sync + 1 register; edge-detect flop runs in parallel).
  - MODE change takes effect 2 edges after MODE changes.
- Mode switch mid-dwell: the counter is discarded, and ch keeps its value until the new mode acts.
- Width rule: SEL_W covers CHANNELS-1. Increments use wrap compare, never modulo 2^SEL_W.
- Elaboration error if CHANNELS<2, WIDTH<1 or DWELL<1.

Decomposition:
- Package mux_scan_pkg:
  - MODE_DIRECT=2'b00, MODE_STEP=2'b01, MODE_SCAN=2'b10, MODE_HOLD=2'b11
  - mode_t typedef
- Sub-module input_sync: parametrised width, 2-flop synchroniser with optional rising-edge output, async active-low reset. Instantiated for SEL/MODE (no edge) and STEP (with edge).
- Dwell counter and channel FSM stay inline.

Test Plan:
All scenarios use CHANNELS=4, WIDTH=4, DWELL=3, DATA_IN=16'hA5C3 (ch0=3, ch1=C, ch2=5, ch3=A) unless stated.
1. Reset: assert RESET_N=0 mid-SCAN, asynchronously to the clock -> DATA_OUT=0, CH_OUT=0, CH_CHANGE=0 immediately; after release in DIRECT with SEL=0, DATA_OUT=3 by edge 3.
2. DIRECT: SEL 0->2 -> on the 3rd edge CH_OUT=2, DATA_OUT=5, CH_CHANGE high for 1 cycle; then change DATA_IN ch2 to 7 -> DATA_OUT=7 one cycle later, no CH_CHANGE.
3. STEP: from ch3, hold STEP high for 20 cycles -> exactly one advance to ch0, DATA_OUT=3, one CH_CHANGE pulse; release and press again -> ch1, DATA_OUT=C.
4. SCAN: enter SCAN at ch0 -> CH_OUT sequence 0,1,2,3,0, each value held exactly 3 cycles; CH_CHANGE every 3rd cycle; DATA_OUT 3,C,5,A,3.
5. HOLD: at ch2, set HOLD, change DATA_IN to 16'hFFFF and pulse STEP -> DATA_OUT stays 5, CH_OUT stays 2, no CH_CHANGE; return to DIRECT with SEL=2 -> DATA_OUT=F.
6. Non-power-of-two (CHANNELS=3, SEL_W=2): DIRECT SEL=3 -> CH_OUT keeps its prior value; SCAN from ch2 wraps to ch0, never 3.
